instruction_loader: RTL

Writer side of the instruction-memory programming port. Receives a program as a byte stream from the UART receiver, assembles little-endian 32-bit words and drives the instruction-fetch write interface (write enable, byte address, word data) one word at a time. While a load is in progress it asserts `o_loading`, which the top level uses to hold the pipeline in halt so the fetch unit's address mux is owned by the loader.

---
 rtl/instruction_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Instruction-memory program loader: assembles little-endian words from the UART byte stream
// and writes them to instruction memory. Optional trailing checksum: `LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter logic [7:0]  START_CMD  = 8'h4C,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    output logic                  o_write_instruction_mem,
    output logic [31:0]           o_instruction_mem_addr,
    output logic [31:0]           o_instruction_mem_data,
    output logic                  o_loading,
    output logic                  o_load_done,
    output logic                  o_load_error,
    output logic [ADDR_WIDTH-2:0] o_word_count
);

    localparam int unsigned WC_W      = ADDR_WIDTH - 1;
    localparam int unsigned MAX_WORDS = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHKSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    logic [23:0] word;
    logic [1:0]  idx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    // Lanes 0..2 are buffered; lane 3 arrives with the write and goes straight to the output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state                   <= S_IDLE;
            word                    <= '0;
            idx                     <= '0;
            o_write_instruction_mem <= 1'b0;
            o_instruction_mem_addr  <= '0;
            o_instruction_mem_data  <= '0;
            o_loading               <= 1'b0;
            o_load_done             <= 1'b0;
            o_load_error            <= 1'b0;
            o_word_count            <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk                     <= '0;
`endif
        end else begin
            o_write_instruction_mem <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_rx_done && i_rx_data == START_CMD) begin
                        state        <= S_RECV;
                        idx          <= '0;
                        o_word_count <= '0;
                        o_loading    <= 1'b1;
                        o_load_done  <= 1'b0;
                        o_load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        chk          <= '0;
`endif
                    end
                end
                S_RECV: begin
                    if (i_rx_done) begin
`ifdef LOADER_CHECKSUM_EN
                        chk <= chk ^ i_rx_data;
`endif
                        if (idx == 2'd3) begin
                            o_write_instruction_mem <= 1'b1;
                            o_instruction_mem_data  <= {i_rx_data, word};
                            o_instruction_mem_addr  <= 32'({o_word_count, 2'b00});
                            o_word_count            <= o_word_count + WC_W'(1);
                            idx                     <= '0;
                            state                   <= S_WRITE;
                        end else begin
                            case (idx)
                                2'd0:    word[7:0]   <= i_rx_data;
                                2'd1:    word[15:8]  <= i_rx_data;
                                default: word[23:16] <= i_rx_data;
                            endcase
                            idx <= idx + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (o_instruction_mem_data == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                        // A byte arriving in the write cycle is already the checksum byte.
                        if (i_rx_done) begin
                            o_loading    <= 1'b0;
                            o_load_done  <= (i_rx_data == chk);
                            o_load_error <= (i_rx_data != chk);
                            state        <= (i_rx_data == chk) ? S_DONE : S_ERROR;
                        end else begin
                            state <= S_CHKSUM;
                        end
`else
                        o_loading   <= 1'b0;
                        o_load_done <= 1'b1;
                        state       <= S_DONE;
`endif
                    end else if (o_word_count == WC_W'(MAX_WORDS)) begin
                        o_loading    <= 1'b0;
                        o_load_error <= 1'b1;
                        state        <= S_ERROR;
                    end else begin
                        state <= S_RECV;
                        if (i_rx_done) begin
                            word[7:0] <= i_rx_data;
                            idx       <= 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            chk       <= chk ^ i_rx_data;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHKSUM: begin
                    if (i_rx_done) begin
                        o_loading    <= 1'b0;
                        o_load_done  <= (i_rx_data == chk);
                        o_load_error <= (i_rx_data != chk);
                        state        <= (i_rx_data == chk) ? S_DONE : S_ERROR;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
